// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: PS/2 host transmit state encoding, command constants and parity helper
package ps2_host_tx_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, WAIT_CLK, SEND, ACK, WAIT_IDLE} tx_state_t;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and frame status between a command source and the PS/2 transmitter
interface ps2_host_tx_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    modport master(output cmd_data, cmd_valid, input cmd_ready, tx_busy, tx_done, tx_error);
    modport slave(input cmd_data, cmd_valid, output cmd_ready, tx_busy, tx_done, tx_error);
endinterface

// File: rtl/ps2_host_tx_sync_edge.sv
// ps2_sync_edge: 2-flop synchroniser for the PS/2 pins plus clock falling-edge pulse
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_sync,
    output logic dat_sync,
    output logic fall_edge
);
    logic [1:0] clk_ff;
    logic [1:0] dat_ff;
    logic       clk_prev;
    // idle bus is high, so reset to 1 to avoid a spurious edge after reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_ff   <= 2'b11;
            dat_ff   <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], ps2_clk_in};
            dat_ff   <= {dat_ff[0], ps2_dat_in};
            clk_prev <= clk_ff[1];
        end
    end
    assign clk_sync  = clk_ff[1];
    assign dat_sync  = dat_ff[1];
    assign fall_edge = clk_prev & ~clk_ff[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-drain clock/data
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic             clock,
    input  logic             reset,
    ps2_host_tx_if.slave     bus,
    input  logic             ps2_clk_in,
    input  logic             ps2_dat_in,
    output logic             ps2_clk_drive_low,
    output logic             ps2_dat_drive_low
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    tx_state_t state, state_next;
    logic [7:0]    shreg;
    logic          parity;
    logic          dat_bit;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic          clk_sync, dat_sync, fall_edge;
    logic          accept, counting, timeout;
    ps2_sync_edge u_sync (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .clk_sync  (clk_sync),
        .dat_sync  (dat_sync),
        .fall_edge (fall_edge)
    );
    assign accept   = bus.cmd_valid && state == IDLE;
    assign counting = state inside {WAIT_CLK, SEND, ACK, WAIT_IDLE};
    assign timeout  = counting && to_cnt == TW'(TIMEOUT_CYCLES);
    always_comb begin
        state_next   = state;
        bus.tx_done  = 1'b0;
        bus.tx_error = timeout;
        if (timeout) state_next = IDLE;
        else begin
            case (state)
                IDLE:      state_next = accept ? INHIBIT : IDLE;
                INHIBIT:   state_next = inh_cnt == IW'(INHIBIT_CYCLES - 1) ? REQ : INHIBIT;
                REQ:       state_next = WAIT_CLK;
                WAIT_CLK:  state_next = SEND;
                SEND:      state_next = fall_edge && bit_cnt == 4'd9 ? ACK : SEND;
                ACK: begin
                    state_next   = fall_edge ? (dat_sync ? IDLE : WAIT_IDLE) : ACK;
                    bus.tx_error = fall_edge && dat_sync;
                end
                WAIT_IDLE: begin
                    state_next  = clk_sync && dat_sync ? IDLE : WAIT_IDLE;
                    bus.tx_done = clk_sync && dat_sync;
                end
                default:   state_next = IDLE;
            endcase
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end
    // shift register holds remaining data bits; dat_bit is the level currently on the data line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            parity  <= 1'b0;
            dat_bit <= 1'b1;
            bit_cnt <= '0;
            inh_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            inh_cnt <= state == INHIBIT ? inh_cnt + 1'b1 : '0;
            to_cnt  <= (!counting || fall_edge) ? '0 : timeout ? to_cnt : to_cnt + 1'b1;
            if (accept) begin
                shreg  <= bus.cmd_data;
                parity <= odd_parity(bus.cmd_data);
            end
            if (state == REQ) dat_bit <= 1'b0;
            if (state == WAIT_CLK) bit_cnt <= '0;
            if (state == SEND && fall_edge) begin
                bit_cnt <= bit_cnt + 1'b1;
                dat_bit <= bit_cnt < 4'd8 ? shreg[0] : bit_cnt == 4'd8 ? parity : 1'b1;
                shreg   <= shreg >> 1;
            end
        end
    end
    assign bus.cmd_ready     = state == IDLE;
    assign bus.tx_busy       = state != IDLE;
    assign ps2_clk_drive_low = state inside {INHIBIT, REQ};
    assign ps2_dat_drive_low = state == REQ || (state inside {WAIT_CLK, SEND} && !dat_bit && !timeout);
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed frames against a PS/2 device model with a 40-cycle clock period
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    logic clk_drive, dat_drive, clk_pin, dat_pin;
    int checks = 0, failures = 0, cyc = 0;
    int n_done = 0, n_err = 0, n_both = 0, n_acc = 0, n_inh = 0, n_req = 0;
    int last_done = 0, prev_done = 0, last_err = 0, last_acc = 0, last_wc = 0;
    logic [1:0] err_drv = 2'b00;
    logic prev_req = 1'b0;
    ps2_host_tx_if bus();
    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(200)) dut (
        .clock            (clk),
        .reset            (rst),
        .bus              (bus),
        .ps2_clk_in       (clk_pin),
        .ps2_dat_in       (dat_pin),
        .ps2_clk_drive_low(clk_drive),
        .ps2_dat_drive_low(dat_drive)
    );
    assign clk_pin = ~(clk_drive | dev_clk_low);
    assign dat_pin = ~(dat_drive | dev_dat_low);
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.tx_done) begin n_done++; prev_done = last_done; last_done = cyc; end
        if (bus.tx_error) begin n_err++; last_err = cyc; err_drv = {clk_drive, dat_drive}; end
        if (bus.tx_done && bus.tx_error) n_both++;
        if (bus.cmd_valid && bus.cmd_ready) begin n_acc++; last_acc = cyc; end
        if (clk_drive && !dat_drive) n_inh++;
        if (clk_drive && dat_drive) n_req++;
        if (prev_req && !clk_drive) last_wc = cyc;
        prev_req = clk_drive && dat_drive;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] b);
        int base, n;
        base = n_acc;
        n = 0;
        bus.cmd_data  = b;
        bus.cmd_valid = 1'b1;
        while (n_acc == base && n < 200) begin tick(); n++; end
        bus.cmd_valid = 1'b0;
    endtask
    // device side: wait for request-to-send, clock nclk pulses, capture 8 data + parity + stop
    task automatic dev_frame(input logic ack, input int nclk, output logic [9:0] bits, output logic ok);
        int n;
        bits = '0;
        ok = 1'b0;
        n = 0;
        while (!(clk_pin && !dat_pin) && n < 2000) begin tick(); n++; end
        if (n < 2000) begin
            ok = 1'b1;
            repeat (5) tick();
            for (int i = 0; i < nclk; i++) begin
                if (i == 10) begin dev_dat_low = ack; repeat (5) tick(); end
                dev_clk_low = 1'b1;
                repeat (20) tick();
                if (i < 10) bits[i] = dat_pin;
                dev_clk_low = 1'b0;
                if (i == 10) dev_dat_low = 1'b0;
                repeat (20) tick();
            end
        end
    endtask
    typedef struct {
        logic [7:0] cmd;
        logic       ack;
        logic       par;
        int         exp_done;
        int         exp_err;
    } vec_t;
    vec_t vecs[4];
    initial begin
        logic [9:0] bits, bits2;
        logic ok, ok2;
        int b_done, b_err, b_inh, b_req, b_acc, n;
        vecs[0] = '{CMD_SET_LEDS, 1'b1, 1'b1, 1, 0};
        vecs[1] = '{8'h01,        1'b1, 1'b0, 1, 0};
        vecs[2] = '{CMD_RESET,    1'b0, 1'b1, 0, 1};
        vecs[3] = '{8'h80,        1'b1, 1'b0, 1, 0};
        bus.cmd_data  = 8'h00;
        bus.cmd_valid = 1'b0;
        repeat (3) tick();
        chk("reset cmd_ready", bus.cmd_ready, 1);
        chk("reset tx_busy", bus.tx_busy, 0);
        chk("reset drives", {clk_drive, dat_drive}, 0);
        chk("reset tx_done", bus.tx_done, 0);
        chk("reset tx_error", bus.tx_error, 0);
        rst = 1'b0;
        repeat (3) tick();
        foreach (vecs[k]) begin
            b_done = n_done; b_err = n_err; b_inh = n_inh; b_req = n_req;
            fork
                send(vecs[k].cmd);
                dev_frame(vecs[k].ack, 11, bits, ok);
            join
            repeat (5) tick();
            chk($sformatf("v%0d request seen", k), ok, 1);
            chk($sformatf("v%0d inhibit cycles", k), n_inh - b_inh, 20);
            chk($sformatf("v%0d req cycles", k), n_req - b_req, 1);
            chk($sformatf("v%0d data byte", k), bits[7:0], vecs[k].cmd);
            chk($sformatf("v%0d parity", k), bits[8], vecs[k].par);
            chk($sformatf("v%0d stop", k), bits[9], 1);
            chk($sformatf("v%0d tx_done count", k), n_done - b_done, vecs[k].exp_done);
            chk($sformatf("v%0d tx_error count", k), n_err - b_err, vecs[k].exp_err);
            chk($sformatf("v%0d cmd_ready after", k), bus.cmd_ready, 1);
            chk($sformatf("v%0d lines released", k), {clk_drive, dat_drive}, 0);
            if (vecs[k].exp_err == 1) chk($sformatf("v%0d drives at error", k), err_drv, 0);
        end
        b_done = n_done; b_acc = n_acc;
        fork
            begin
                bus.cmd_data = CMD_ENABLE;
                bus.cmd_valid = 1'b1;
                n = 0;
                while (n_acc == b_acc && n < 200) begin tick(); n++; end
                bus.cmd_data = 8'h00;
                n = 0;
                while (n_acc == b_acc + 1 && n < 2000) begin tick(); n++; end
                bus.cmd_valid = 1'b0;
            end
            begin
                dev_frame(1'b1, 11, bits, ok);
                dev_frame(1'b1, 11, bits2, ok2);
            end
        join
        repeat (5) tick();
        chk("b2b first byte", bits[7:0], CMD_ENABLE);
        chk("b2b first parity", bits[8], 0);
        chk("b2b second byte", {ok2, bits2[7:0]}, 9'h100);
        chk("b2b second parity", bits2[8], 1);
        chk("b2b done count", n_done - b_done, 2);
        chk("b2b accept after done", last_acc - prev_done, 1);
        b_err = n_err; b_done = n_done;
        send(8'h00);
        n = 0;
        while (n_err == b_err && n < 1000) begin tick(); n++; end
        repeat (5) tick();
        chk("timeout error count", n_err - b_err, 1);
        chk("timeout latency", last_err - last_wc, 200);
        chk("timeout drives at error", err_drv, 0);
        chk("timeout no done", n_done - b_done, 0);
        chk("timeout cmd_ready", bus.cmd_ready, 1);
        fork
            send(8'h00);
            dev_frame(1'b1, 5, bits, ok);
        join
        chk("mid-frame D4 driven", {bus.tx_busy, dat_drive}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("reset releases lines", {clk_drive, dat_drive}, 0);
        chk("reset cmd_ready", bus.cmd_ready, 1);
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        b_done = n_done;
        fork
            send(CMD_RESET);
            dev_frame(1'b1, 11, bits, ok);
        join
        repeat (5) tick();
        chk("post-reset byte", bits[7:0], CMD_RESET);
        chk("post-reset parity", bits[8], 1);
        chk("post-reset done", n_done - b_done, 1);
        b_acc = n_acc; b_done = n_done;
        fork
            send(8'h12);
            dev_frame(1'b1, 11, bits, ok);
            begin
                repeat (60) tick();
                chk("busy during frame", bus.tx_busy, 1);
                bus.cmd_data = 8'h55;
                bus.cmd_valid = 1'b1;
                repeat (10) tick();
                bus.cmd_valid = 1'b0;
            end
        join
        repeat (50) tick();
        chk("ignore byte received", bits[7:0], 8'h12);
        chk("ignore accept count", n_acc - b_acc, 1);
        chk("ignore done count", n_done - b_done, 1);
        chk("ignore no new frame", bus.tx_busy, 0);
        chk("done and error overlap", n_both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

- Host-to-device PS/2 transmitter: the send side of the keyboard link, complementing the existing receive/scan-code path.
- Takes one command byte at a time (e.g. 0xFF reset, 0xED set LEDs, 0xF4 enable) and drives the PS/2 request-to-send sequence over open-drain clock and data lines.
- Serialises 8 data bits LSB first, then odd parity and stop, then checks the device acknowledge.
- Sits beside the keyboard receiver in the top level and shares the PS2_CLK/PS2_DAT pins through tri-state buffers.

## Interface
Parameters:
- INHIBIT_CYCLES, 5000: cycles the clock line is held low before the start bit (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum cycles allowed between device clock falling edges, or waiting for bus idle (15 ms).

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset.
- cmd_data  in  8  byte to send, sampled on accept.
- cmd_valid  in  1  request to send cmd_data.
- cmd_ready  out  1  high only in IDLE; accept occurs when cmd_valid && cmd_ready.
- ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pin level (asynchronous).
- ps2_clk_drive_low  out  1  1 = pull PS2_CLK low; 0 = release (high-Z).
- ps2_dat_drive_low  out  1  1 = pull PS2_DAT low; 0 = release.
- tx_busy  out  1  high from accept until return to IDLE; the top level uses it to gate the receiver.
- tx_done  out  1  one-cycle pulse on a successful, acknowledged frame.
- tx_error  out  1  one-cycle pulse on NACK or timeout.

## Operation
- Reset values: cmd_ready=1; tx_busy=0; both drive_low outputs=0 (lines released); tx_done=0; tx_error=0; state IDLE.
- Reset mid-frame releases both lines immediately (asynchronously).
- Pin inputs pass through a 2-flop synchroniser. fall_edge is a one-cycle pulse when the synced clock goes 1→0.
- Odd parity bit = ~^cmd_data.
- IDLE: on accept, latch the byte into a shift register. Next state INHIBIT.
- INHIBIT: clk_drive=1, dat_drive=0 for exactly INHIBIT_CYCLES cycles. Next state REQ.
- REQ: clk_drive=1, dat_drive=1 (start bit) for 1 cycle. Next state WAIT_CLK.
- WAIT_CLK: release the clock, keep dat_drive=1. Clear the bit counter. Next state SEND.
- SEND: on each fall_edge, drive the next bit. dat_drive = ~bit.
  - Edges 1–8: D0..D7.
  - Edge 9: parity.
  - Edge 10: release data (stop bit), go to ACK.
- ACK: on the next fall_edge, sample synced data.
  - 0 → go to WAIT_IDLE.
  - 1 → pulse tx_error, go to IDLE.
- WAIT_IDLE: when synced clock and data are both 1, pulse tx_done and go to IDLE.
- Timeout counter:
  - Clears on entry to WAIT_CLK and on every fall_edge.
  - Counts in WAIT_CLK, SEND, ACK and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES: release both lines, pulse tx_error, go to IDLE.
- cmd_valid while not ready is ignored; no queueing, and the byte is not captured.
- tx_done and tx_error never assert in the same cycle.

## Timing
- Accept at edge N:
  - clk_drive rises at N+1.
  - dat_drive rises at N+1+INHIBIT_CYCLES.
  - clk_drive falls one cycle later.
- A pin falling edge yields fall_edge 2 cycles later; the data bit changes on the cycle after fall_edge.
  - Total pin-fall to data-change latency is 3 cycles, well inside the device's low half-period (≥30 µs).
- ACK data is sampled in the same cycle as fall_edge 11.
- tx_done lasts exactly 1 cycle.
- cmd_ready returns high the cycle after tx_done/tx_error, so back-to-back commands are possible.
- Widths:
  - Bit counter: 4 bits.
  - Inhibit counter: $clog2(INHIBIT_CYCLES+1) bits.
  - Timeout counter: $clog2(TIMEOUT_CYCLES+1) bits, saturating.

## Structure
- Shared ps2_defs header/package holds:
  - State encoding (IDLE, INHIBIT, REQ, WAIT_CLK, SEND, ACK, WAIT_IDLE).
  - Command constants CMD_RESET=8'hFF, CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4.
  - ACK_BYTE=8'hFA.
- One sub-module: ps2_sync_edge (2-flop synchroniser plus falling-edge detect for the clock, synced data out). It is reusable by the receiver.
- Expected size: ~200 lines of RTL.

## Test plan
Bench uses INHIBIT_CYCLES=20 and TIMEOUT_CYCLES=200, with a device model clocking at a 40-cycle period.
- Send 0xED with the device ACKing:
  - Clock held low exactly 20 cycles.
  - Device captures bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - One tx_done pulse; cmd_ready returns.
- Send 0xF4 then 0x00 back-to-back:
  - Parity bits 0 then 1.
  - Two tx_done pulses; second accept the cycle after the first tx_done.
- Send 0xFF, device leaves data high at ACK → one tx_error pulse, no tx_done, lines released.
- Device never clocks after REQ → tx_error exactly 200 cycles after WAIT_CLK entry; both drive_low outputs = 0.
- Assert reset during the SEND of bit 4 → drive outputs 0 in the same cycle, cmd_ready=1; next command 0xFF completes normally.
- cmd_valid with 0x55 during busy → ignored; the device receives only the original byte.
